// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer for the MIPS core.
// Define PC_SEQ_PERF_EN to add the instr_count / stall_cycles performance counters.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int unsigned WAIT_MAX     = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        br_take,
    input  logic [31:0] br_target,
    input  logic        jmp_take,
    input  logic [31:0] jmp_target,
    input  logic        halt,
    output logic        halted,
    output logic        fetch_err
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0] instr_count,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DELIVER,
        S_ERR,
        S_HALTED
    } state_t;

    // Last counter value seen in WAIT before giving up on the fetch.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      state;
    logic [31:0] fetch_pc;
    logic [7:0]  wait_cnt;
    logic [31:0] next_pc;

    always_comb begin
        next_pc = pc_plus4;
        if (jmp_take) begin
            next_pc = jmp_target & ~32'h3;
        end else if (br_take) begin
            next_pc = br_target & ~32'h3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_VECTOR;
            wait_cnt    <= 8'd0;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_VECTOR;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            pc          <= RESET_VECTOR;
            pc_plus4    <= RESET_VECTOR + 32'd4;
            halted      <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            fetch_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    state     <= S_REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= fetch_pc;
                end
                S_REQ, S_WAIT: begin
                    // Ack wins over the timeout when both land in the same cycle.
                    if (imem_ack) begin
                        state       <= S_DELIVER;
                        imem_req    <= 1'b0;
                        instr       <= imem_rdata;
                        pc          <= fetch_pc;
                        pc_plus4    <= fetch_pc + 32'd4;
                        instr_valid <= 1'b1;
                    end else if (state == S_REQ) begin
                        state    <= S_WAIT;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= S_ERR;
                        imem_req  <= 1'b0;
                        fetch_err <= 1'b1;
                        fetch_pc  <= EXC_VECTOR;
                        wait_cnt  <= wait_cnt + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DELIVER: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        if (halt) begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end else begin
                            state     <= S_REQ;
                            fetch_pc  <= next_pc;
                            imem_req  <= 1'b1;
                            imem_addr <= next_pc;
                        end
                    end
                end
                S_ERR: begin
                    state     <= S_REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= fetch_pc;
                end
                S_HALTED: begin
                    state <= S_HALTED;
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count  <= 32'd0;
            stall_cycles <= 32'd0;
        end else if (state == S_DELIVER) begin
            if (stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end else begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer; one table row per clock cycle.
// Extra counter checks are compiled in when PC_SEQ_PERF_EN is defined.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        br_take;
    logic [31:0] br_target;
    logic        jmp_take;
    logic [31:0] jmp_target;
    logic        halt;
    logic        halted;
    logic        fetch_err;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] instr_count;
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;
    int row    = 0;

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    // Inputs driven during one cycle and the registered outputs expected in that cycle.
    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        br;
        logic [31:0] brt;
        logic        jmp;
        logic [31:0] jmpt;
        logic        halt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_err;
        logic        e_halted;
    } vec_t;

    vec_t vecs[$];

    pc_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .EXC_VECTOR  (32'h0000_0080),
        .WAIT_MAX    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .stall      (stall),
        .br_take    (br_take),
        .br_target  (br_target),
        .jmp_take   (jmp_take),
        .jmp_target (jmp_target),
        .halt       (halt),
        .halted     (halted),
        .fetch_err  (fetch_err)
`ifdef PC_SEQ_PERF_EN
        ,
        .instr_count (instr_count),
        .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t blank();
        vec_t v;
        v.rst = 1'b0;  v.ack = 1'b0;  v.rdata = JUNK;  v.stall = 1'b0;
        v.br = 1'b0;   v.brt = 32'd0; v.jmp = 1'b0;    v.jmpt = 32'd0;
        v.halt = 1'b0; v.e_req = 1'b0; v.e_addr = 32'd0; v.e_valid = 1'b0;
        v.e_pc = 32'd0; v.e_instr = 32'd0; v.e_err = 1'b0; v.e_halted = 1'b0;
        return v;
    endfunction

    function automatic vec_t v_idle(logic rst);
        vec_t v = blank();
        v.rst = rst;
        return v;
    endfunction

    function automatic vec_t v_req(logic [31:0] addr, logic ack, logic [31:0] rdata);
        vec_t v = blank();
        v.ack = ack; v.rdata = rdata; v.e_req = 1'b1; v.e_addr = addr;
        return v;
    endfunction

    function automatic vec_t v_del(logic [31:0] pcv, logic [31:0] iv, logic stl);
        vec_t v = blank();
        v.stall = stl; v.e_valid = 1'b1; v.e_pc = pcv; v.e_instr = iv;
        v.ack = 1'b1;  // stray ack outside a fetch must be ignored
        return v;
    endfunction

    function automatic vec_t v_err();
        vec_t v = blank();
        v.e_err = 1'b1;
        return v;
    endfunction

    function automatic vec_t v_halt(logic rst);
        vec_t v = blank();
        v.rst = rst; v.e_halted = 1'b1; v.ack = 1'b1;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        reset      = v.rst;
        imem_ack   = v.ack;
        imem_rdata = v.rdata;
        stall      = v.stall;
        br_take    = v.br;
        br_target  = v.brt;
        jmp_take   = v.jmp;
        jmp_target = v.jmpt;
        halt       = v.halt;
    endtask

    task automatic checkOutput(vec_t v);
        check("imem_req", {31'd0, imem_req}, {31'd0, v.e_req});
        check("instr_valid", {31'd0, instr_valid}, {31'd0, v.e_valid});
        check("fetch_err", {31'd0, fetch_err}, {31'd0, v.e_err});
        check("halted", {31'd0, halted}, {31'd0, v.e_halted});
        if (v.e_req) check("imem_addr", imem_addr, v.e_addr);
        if (v.e_valid) begin
            check("pc", pc, v.e_pc);
            check("instr", instr, v.e_instr);
            check("pc_plus4", pc_plus4, v.e_pc + 32'd4);
        end
    endtask

    task automatic run_vec(vec_t v);
        @(negedge clk);
        applyStimulus(v);
        checkOutput(v);
        row++;
    endtask

    initial begin
        vec_t v;

        // Zero-wait fetch of 0,4 then a 5-cycle stall at pc=8 with a branch pulsed mid-stall.
        vecs.push_back(v_idle(1'b0));
        vecs.push_back(v_req(32'h0, 1'b1, 32'hA000_0000));
        vecs.push_back(v_del(32'h0, 32'hA000_0000, 1'b0));
        vecs.push_back(v_req(32'h4, 1'b1, 32'hA000_0004));
        vecs.push_back(v_del(32'h4, 32'hA000_0004, 1'b0));
        vecs.push_back(v_req(32'h8, 1'b1, 32'hA000_0008));
        vecs.push_back(v_del(32'h8, 32'hA000_0008, 1'b1));
        v = v_del(32'h8, 32'hA000_0008, 1'b1); v.br = 1'b1; v.brt = 32'h200; vecs.push_back(v);
        vecs.push_back(v_del(32'h8, 32'hA000_0008, 1'b1));
        vecs.push_back(v_del(32'h8, 32'hA000_0008, 1'b1));
        vecs.push_back(v_del(32'h8, 32'hA000_0008, 1'b1));
        vecs.push_back(v_del(32'h8, 32'hA000_0008, 1'b0));
        vecs.push_back(v_req(32'hC, 1'b1, 32'hA000_000C));
        vecs.push_back(v_del(32'hC, 32'hA000_000C, 1'b0));
        // Jump beats branch at pc=16; then an unaligned branch target is word-aligned.
        vecs.push_back(v_req(32'h10, 1'b1, 32'hA000_0010));
        v = v_del(32'h10, 32'hA000_0010, 1'b0);
        v.jmp = 1'b1; v.jmpt = 32'h40; v.br = 1'b1; v.brt = 32'h80; vecs.push_back(v);
        vecs.push_back(v_req(32'h40, 1'b1, 32'hA000_0040));
        v = v_del(32'h40, 32'hA000_0040, 1'b0); v.br = 1'b1; v.brt = 32'h103; vecs.push_back(v);
        vecs.push_back(v_req(32'h100, 1'b0, JUNK));
        // Reset lands while in WAIT: fetch restarts at the reset vector.
        v = v_req(32'h100, 1'b0, JUNK); v.rst = 1'b1; vecs.push_back(v);
        vecs.push_back(v_idle(1'b0));
        vecs.push_back(v_req(32'h0, 1'b1, 32'hB000_0000));
        vecs.push_back(v_del(32'h0, 32'hB000_0000, 1'b0));
        // Ack three cycles late at address 4: four request cycles total.
        vecs.push_back(v_req(32'h4, 1'b0, JUNK));
        vecs.push_back(v_req(32'h4, 1'b0, JUNK));
        vecs.push_back(v_req(32'h4, 1'b0, JUNK));
        vecs.push_back(v_req(32'h4, 1'b1, 32'hB000_0004));
        vecs.push_back(v_del(32'h4, 32'hB000_0004, 1'b0));
        // No ack at address 8: one REQ plus eight WAIT cycles, then the error vector.
        for (int i = 0; i < 9; i++) vecs.push_back(v_req(32'h8, 1'b0, JUNK));
        vecs.push_back(v_err());
        vecs.push_back(v_req(32'h80, 1'b1, 32'hC000_0080));
        vecs.push_back(v_del(32'h80, 32'hC000_0080, 1'b0));

        reset = 1'b1;
        applyStimulus(v_idle(1'b1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
`ifdef PC_SEQ_PERF_EN
        check("rst_instr_count", instr_count, 32'd0);
        check("rst_stall_cycles", stall_cycles, 32'd0);
`endif

        foreach (vecs[i]) run_vec(vecs[i]);

        // Halt on acceptance at pc=12 after a fresh reset.
        v = v_req(32'h84, 1'b0, JUNK); v.rst = 1'b1; run_vec(v);
        run_vec(v_idle(1'b0));
        for (int k = 0; k < 4; k++) begin
            run_vec(v_req(32'(4 * k), 1'b1, 32'hD000_0000 + 32'(k)));
            v = v_del(32'(4 * k), 32'hD000_0000 + 32'(k), 1'b0);
            v.halt = (k == 3);
            run_vec(v);
        end
        for (int k = 0; k < 20; k++) run_vec(v_halt(1'b0));
`ifdef PC_SEQ_PERF_EN
        check("instr_count", instr_count, 32'd4);
        check("stall_cycles", stall_cycles, 32'd0);
`endif
        run_vec(v_halt(1'b1));
        run_vec(v_idle(1'b0));
        run_vec(v_req(32'h0, 1'b1, 32'hE000_0000));
        run_vec(v_del(32'h0, 32'hE000_0000, 1'b0));
        run_vec(v_req(32'h4, 1'b0, JUNK));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
